// File: rtl/bcd_range_counter.sv
// Two-digit BCD counter over a MIN_VALUE..MAX_VALUE range, for clock time fields.
// It has clear, validated load, up/down counting and a registered carry/borrow for cascading.
module bcd_range_counter #(
   parameter int MIN_VALUE   = 0,
   parameter int MAX_VALUE   = 59,
   parameter int RESET_VALUE = MIN_VALUE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       up_dn,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry_out,
   output logic       at_max,
   output logic       at_min,
   output logic       load_err
);

   localparam logic [3:0] MIN_TENS = 4'(MIN_VALUE / 10);
   localparam logic [3:0] MIN_ONES = 4'(MIN_VALUE % 10);
   localparam logic [3:0] MAX_TENS = 4'(MAX_VALUE / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_VALUE % 10);
   localparam logic [3:0] RST_TENS = 4'(RESET_VALUE / 10);
   localparam logic [3:0] RST_ONES = 4'(RESET_VALUE % 10);

   generate
      if (MIN_VALUE < 0 || MIN_VALUE >= MAX_VALUE || MAX_VALUE > 99) begin : g_bad_range
         $fatal(1, "bcd_range_counter: require 0 <= MIN_VALUE < MAX_VALUE <= 99");
      end
      if (RESET_VALUE < MIN_VALUE || RESET_VALUE > MAX_VALUE) begin : g_bad_reset
         $fatal(1, "bcd_range_counter: RESET_VALUE must lie in MIN_VALUE..MAX_VALUE");
      end
   endgenerate

   logic [3:0] next_tens;
   logic [3:0] next_ones;
   logic       next_carry;
   logic       next_err;
   logic       next_at_max;
   logic       next_at_min;
   logic       load_ok;
   int         load_value;

   // Range check runs in signed int so a zero MIN_VALUE is not a degenerate compare.
   always_comb begin
      load_value = 10 * int'(load_tens) + int'(load_ones);
      load_ok    = (load_tens <= 4'd9) && (load_ones <= 4'd9) &&
                   (load_value >= MIN_VALUE) && (load_value <= MAX_VALUE);
   end

   always_comb begin
      next_tens  = tens;
      next_ones  = ones;
      next_carry = 1'b0;
      next_err   = 1'b0;
      if (clr) begin
         next_tens = MIN_TENS;
         next_ones = MIN_ONES;
      end else if (load) begin
         if (load_ok) begin
            next_tens = load_tens;
            next_ones = load_ones;
         end else begin
            next_err = 1'b1;
         end
      end else if (en) begin
         if (up_dn) begin
            if (at_max) begin
               next_tens  = MIN_TENS;
               next_ones  = MIN_ONES;
               next_carry = 1'b1;
            end else if (ones == 4'd9) begin
               next_ones = 4'd0;
               next_tens = tens + 4'd1;
            end else begin
               next_ones = ones + 4'd1;
            end
         end else begin
            if (at_min) begin
               next_tens  = MAX_TENS;
               next_ones  = MAX_ONES;
               next_carry = 1'b1;
            end else if (ones == 4'd0) begin
               next_ones = 4'd9;
               next_tens = tens - 4'd1;
            end else begin
               next_ones = ones - 4'd1;
            end
         end
      end
      next_at_max = (next_tens == MAX_TENS) && (next_ones == MAX_ONES);
      next_at_min = (next_tens == MIN_TENS) && (next_ones == MIN_ONES);
   end

   // The range flags are registered from the next count, so the wrap decisions above can use them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tens      <= RST_TENS;
         ones      <= RST_ONES;
         carry_out <= 1'b0;
         load_err  <= 1'b0;
         at_max    <= (RESET_VALUE == MAX_VALUE);
         at_min    <= (RESET_VALUE == MIN_VALUE);
      end else begin
         tens      <= next_tens;
         ones      <= next_ones;
         carry_out <= next_carry;
         load_err  <= next_err;
         at_max    <= next_at_max;
         at_min    <= next_at_min;
      end
   end

endmodule

// File: tb/tb_bcd_range_counter.sv
// Bench for bcd_range_counter. It drives four instances: seconds, minutes cascaded from seconds, 1..12 hours and 0..23 hours.
// An integer reference model fills a scoreboard queue, and each test task pops and compares.
module tb_bcd_range_counter;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       carry;
      logic       at_max;
      logic       at_min;
      logic       load_err;
   } obs_t;
   typedef obs_t [3:0] snap_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] clr_s, load_s, en_s, up_s;
   logic [3:0] lt_s [4];
   logic [3:0] lo_s [4];
   logic [3:0] tens_w [4];
   logic [3:0] ones_w [4];
   logic [3:0] carry_w, max_w, min_w, err_w;

   snap_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    m_cnt [4];
   bit    m_carry [4];
   int    m_min [4] = '{0, 0, 1, 0};
   int    m_max [4] = '{59, 59, 12, 23};
   int    m_rst [4] = '{0, 0, 12, 0};

   always #5 clk = ~clk;

   bcd_range_counter #(.MIN_VALUE(0), .MAX_VALUE(59)) u_sec (
      .clk(clk), .reset(reset), .en(en_s[0]), .up_dn(up_s[0]), .clr(clr_s[0]), .load(load_s[0]),
      .load_tens(lt_s[0]), .load_ones(lo_s[0]), .tens(tens_w[0]), .ones(ones_w[0]),
      .carry_out(carry_w[0]), .at_max(max_w[0]), .at_min(min_w[0]), .load_err(err_w[0]));

   bcd_range_counter #(.MIN_VALUE(0), .MAX_VALUE(59)) u_min (
      .clk(clk), .reset(reset), .en(carry_w[0] | en_s[1]), .up_dn(up_s[1]), .clr(clr_s[1]),
      .load(load_s[1]), .load_tens(lt_s[1]), .load_ones(lo_s[1]), .tens(tens_w[1]), .ones(ones_w[1]),
      .carry_out(carry_w[1]), .at_max(max_w[1]), .at_min(min_w[1]), .load_err(err_w[1]));

   bcd_range_counter #(.MIN_VALUE(1), .MAX_VALUE(12), .RESET_VALUE(12)) u_h12 (
      .clk(clk), .reset(reset), .en(en_s[2]), .up_dn(up_s[2]), .clr(clr_s[2]), .load(load_s[2]),
      .load_tens(lt_s[2]), .load_ones(lo_s[2]), .tens(tens_w[2]), .ones(ones_w[2]),
      .carry_out(carry_w[2]), .at_max(max_w[2]), .at_min(min_w[2]), .load_err(err_w[2]));

   bcd_range_counter #(.MIN_VALUE(0), .MAX_VALUE(23)) u_h24 (
      .clk(clk), .reset(reset), .en(en_s[3]), .up_dn(up_s[3]), .clr(clr_s[3]), .load(load_s[3]),
      .load_tens(lt_s[3]), .load_ones(lo_s[3]), .tens(tens_w[3]), .ones(ones_w[3]),
      .carry_out(carry_w[3]), .at_max(max_w[3]), .at_min(min_w[3]), .load_err(err_w[3]));

   function automatic obs_t make_obs(int i, bit cy, bit er);
      obs_t o;
      o.tens     = 4'(m_cnt[i] / 10);
      o.ones     = 4'(m_cnt[i] % 10);
      o.carry    = cy;
      o.at_max   = (m_cnt[i] == m_max[i]);
      o.at_min   = (m_cnt[i] == m_min[i]);
      o.load_err = er;
      return o;
   endfunction

   function automatic obs_t model_step(int i, bit c, bit l, int lt, int lo, bit e, bit u);
      int v  = m_cnt[i];
      int lv = lt * 10 + lo;
      bit cy = 1'b0;
      bit er = 1'b0;
      if (c) v = m_min[i];
      else if (l) begin
         if (lt <= 9 && lo <= 9 && lv >= m_min[i] && lv <= m_max[i]) v = lv;
         else er = 1'b1;
      end else if (e) begin
         if (u) begin
            if (v == m_max[i]) begin v = m_min[i]; cy = 1'b1; end
            else v = v + 1;
         end else begin
            if (v == m_min[i]) begin v = m_max[i]; cy = 1'b1; end
            else v = v - 1;
         end
      end
      m_cnt[i]   = v;
      m_carry[i] = cy;
      return make_obs(i, cy, er);
   endfunction

   function automatic snap_t model_reset();
      snap_t s;
      for (int i = 0; i < 4; i++) begin
         m_cnt[i]   = m_rst[i];
         m_carry[i] = 1'b0;
         s[i]       = make_obs(i, 1'b0, 1'b0);
      end
      return s;
   endfunction

   function automatic snap_t sample();
      snap_t s;
      for (int i = 0; i < 4; i++) begin
         s[i].tens     = tens_w[i];
         s[i].ones     = ones_w[i];
         s[i].carry    = carry_w[i];
         s[i].at_max   = max_w[i];
         s[i].at_min   = min_w[i];
         s[i].load_err = err_w[i];
      end
      return s;
   endfunction

   // Drives one instance for one edge. The other instances idle, except that the minutes instance follows the seconds carry.
   task automatic drive(int idx, bit c, bit l, int lt, int lo, bit e, bit u);
      snap_t s;
      bit    c0 = m_carry[0];
      clr_s = '0; load_s = '0; en_s = '0; up_s = '1;
      for (int i = 0; i < 4; i++) begin lt_s[i] = 4'd0; lo_s[i] = 4'd0; end
      clr_s[idx] = c; load_s[idx] = l; en_s[idx] = e; up_s[idx] = u;
      lt_s[idx] = 4'(lt); lo_s[idx] = 4'(lo);
      for (int i = 0; i < 4; i++) begin
         if (i == idx) s[i] = model_step(i, c, l, lt, lo, (i == 1) ? (e | c0) : e, u);
         else          s[i] = model_step(i, 1'b0, 1'b0, 0, 0, (i == 1) ? c0 : 1'b0, 1'b1);
      end
      sb.push_back(s);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      snap_t exp_s, got_s;
      reset = 1'b0;
      #2;
      sb.push_back(model_reset());
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL reset_async got %h exp %h", got_s, exp_s);
      end
      @(posedge clk); #1;
      sb.push_back(model_reset());
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL reset_held got %h exp %h", got_s, exp_s);
      end
      reset = 1'b1;
   endtask

   task automatic test_count_up();
      snap_t exp_s, got_s;
      int pulses = 0;
      for (int k = 0; k < 61; k++) begin
         if (k < 60) drive(0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
         else        drive(0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
         exp_s = sb.pop_front(); got_s = sample(); checks++;
         if (got_s[0].carry === 1'b1) pulses++;
         if (got_s !== exp_s) begin
            errors++; $display("[TB] FAIL count_up step %0d got %h exp %h", k, got_s, exp_s);
         end
      end
      checks++;
      if (pulses !== 1) begin
         errors++; $display("[TB] FAIL count_up_pulses got %0d exp 1", pulses);
      end
   endtask

   task automatic test_count_down();
      snap_t exp_s, got_s;
      drive(2, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL down_load01 got %h exp %h", got_s, exp_s);
      end
      for (int k = 0; k < 5; k++) begin
         drive(2, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
         exp_s = sb.pop_front(); got_s = sample(); checks++;
         if (got_s !== exp_s) begin
            errors++; $display("[TB] FAIL count_down step %0d got %h exp %h", k, got_s, exp_s);
         end
      end
   endtask

   task automatic test_load();
      snap_t exp_s, got_s;
      int ld [6][2] = '{'{2, 3}, '{2, 4}, '{1, 10}, '{9, 9}, '{0, 0}, '{2, 3}};
      for (int k = 0; k < 6; k++) begin
         drive(3, 1'b0, 1'b1, ld[k][0], ld[k][1], 1'b0, 1'b1);
         exp_s = sb.pop_front(); got_s = sample(); checks++;
         if (got_s !== exp_s) begin
            errors++; $display("[TB] FAIL load %0d%0d got %h exp %h", ld[k][0], ld[k][1], got_s, exp_s);
         end
      end
      drive(3, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL load_then_wrap got %h exp %h", got_s, exp_s);
      end
   endtask

   task automatic test_priority();
      snap_t exp_s, got_s;
      int st [6][5] = '{'{0, 1, 5, 9, 0}, '{1, 1, 2, 3, 1}, '{0, 1, 5, 9, 0},
                        '{1, 1, 10, 10, 1}, '{0, 1, 3, 0, 1}, '{0, 1, 7, 0, 1}};
      for (int k = 0; k < 6; k++) begin
         drive(0, st[k][0] != 0, st[k][1] != 0, st[k][2], st[k][3], st[k][4] != 0, 1'b1);
         exp_s = sb.pop_front(); got_s = sample(); checks++;
         if (got_s !== exp_s) begin
            errors++; $display("[TB] FAIL priority step %0d got %h exp %h", k, got_s, exp_s);
         end
      end
   endtask

   task automatic test_cascade();
      snap_t exp_s, got_s;
      int pulses = 0;
      drive(0, 1'b0, 1'b1, 5, 9, 1'b0, 1'b1);
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL cascade_set_sec got %h exp %h", got_s, exp_s);
      end
      drive(1, 1'b0, 1'b1, 5, 9, 1'b0, 1'b1);
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL cascade_set_min got %h exp %h", got_s, exp_s);
      end
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'b0, 1'b0, 0, 0, k == 0, 1'b1);
         exp_s = sb.pop_front(); got_s = sample(); checks++;
         if (got_s[1].carry === 1'b1) pulses++;
         if (got_s !== exp_s) begin
            errors++; $display("[TB] FAIL cascade step %0d got %h exp %h", k, got_s, exp_s);
         end
      end
      checks++;
      if (pulses !== 1) begin
         errors++; $display("[TB] FAIL cascade_min_pulses got %0d exp 1", pulses);
      end
   endtask

   task automatic test_reset_mid_count();
      snap_t exp_s, got_s;
      drive(0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL mid_clear got %h exp %h", got_s, exp_s);
      end
      for (int k = 0; k < 37; k++) begin
         drive(0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
         exp_s = sb.pop_front(); got_s = sample(); checks++;
         if (got_s !== exp_s) begin
            errors++; $display("[TB] FAIL mid_count step %0d got %h exp %h", k, got_s, exp_s);
         end
      end
      #3;
      reset = 1'b0;
      #1;
      sb.push_back(model_reset());
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL mid_reset_immediate got %h exp %h", got_s, exp_s);
      end
      @(posedge clk); #1;
      sb.push_back(model_reset());
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL mid_reset_held got %h exp %h", got_s, exp_s);
      end
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
      exp_s = sb.pop_front(); got_s = sample(); checks++;
      if (got_s !== exp_s) begin
         errors++; $display("[TB] FAIL mid_resume got %h exp %h", got_s, exp_s);
      end
   endtask

   initial begin
      reset = 1'b1;
      clr_s = '0; load_s = '0; en_s = '0; up_s = '1;
      for (int i = 0; i < 4; i++) begin lt_s[i] = 4'd0; lo_s[i] = 4'd0; end
      #1;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_priority();
      test_cascade();
      test_reset_mid_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
